// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (read-only)
// and execute (read/write). One transaction in flight; level req/ready towards requesters.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_ready,
    input  logic              e_req,
    input  logic              e_we,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_wdata,
    output logic [DATA_W-1:0] e_rdata,
    output logic              e_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        dbg_state_o
);

    // Handshakes: a requester raises req with addr/we/wdata stable and holds them until it
    // sees its ready; ready then stays high until that req is seen low. Towards memory,
    // mem_req and mem_* stay stable until mem_ack completes the access.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic GNT_F = 1'b0;
    localparam logic GNT_E = 1'b1;

    state_t              state_q;
    logic                grant_q;
    logic                last_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   f_rdata_q;
    logic [DATA_W-1:0]   e_rdata_q;
    logic                f_ready_q;
    logic                e_ready_q;

    logic                pick_e_d;
    logic                granted_req;

    // Execute wins when it is alone, or on a tie when fetch was served last.
    always_comb begin
        pick_e_d = e_req & (~f_req | (last_q == GNT_F));
    end

    assign granted_req = (grant_q == GNT_E) ? e_req : f_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= GNT_F;
            last_q      <= GNT_E;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            f_rdata_q   <= '0;
            e_rdata_q   <= '0;
            f_ready_q   <= 1'b0;
            e_ready_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (f_req || e_req) begin
                        grant_q   <= pick_e_d;
                        mem_req_q <= 1'b1;
                        state_q   <= ST_BUSY;
                        if (pick_e_d) begin
                            mem_addr_q  <= e_addr;
                            mem_we_q    <= e_we;
                            mem_wdata_q <= e_wdata;
                        end else begin
                            mem_addr_q  <= f_addr;
                            mem_we_q    <= 1'b0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        last_q    <= grant_q;
                        state_q   <= ST_DONE;
                        if (grant_q == GNT_E) begin
                            e_ready_q <= 1'b1;
                            if (!mem_we_q) begin
                                e_rdata_q <= mem_rdata;
                            end
                        end else begin
                            f_ready_q <= 1'b1;
                            f_rdata_q <= mem_rdata;
                        end
                    end
                end
                ST_DONE: begin
                    // A new grant waits for IDLE, even if the other requester is pending.
                    if (!granted_req) begin
                        f_ready_q <= 1'b0;
                        e_ready_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign f_rdata     = f_rdata_q;
    assign e_rdata     = e_rdata_q;
    assign f_ready     = f_ready_q;
    assign e_ready     = e_ready_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized concurrent traffic, with a
// memory responder, a grant-order reference model and expected-data queues.
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_rdata;
    logic          f_ready;
    logic          e_req;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [DW-1:0] e_rdata;
    logic          e_ready;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic [1:0]    dbg_state;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .f_req      (f_req),
        .f_addr     (f_addr),
        .f_rdata    (f_rdata),
        .f_ready    (f_ready),
        .e_req      (e_req),
        .e_we       (e_we),
        .e_addr     (e_addr),
        .e_wdata    (e_wdata),
        .e_rdata    (e_rdata),
        .e_ready    (e_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Memory contents seen by the responder, and the reference view of what reads must return.
    logic [DW-1:0] mem_array [256];
    logic [DW-1:0] ref_mem   [256];
    logic [DW-1:0] f_exp_q [$];
    logic [DW-1:0] e_exp_q [$];
    logic [DW-1:0] e_last_read = '0;
    int            grant_log [$];
    int            ack_delay = 0;
    bit            ack_linger_en = 1'b0;

    logic          f_req_s, e_req_s, e_we_s, rst_s;
    logic [AW-1:0] f_addr_s, e_addr_s;
    logic [DW-1:0] e_wdata_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string msg);
        checks++;
        errors++;
        $display("FAIL %s", msg);
    endtask

    // Inputs as the DUT saw them at the most recent rising edge.
    always @(posedge clk) begin
        f_req_s   <= f_req;
        e_req_s   <= e_req;
        e_we_s    <= e_we;
        rst_s     <= rst;
        f_addr_s  <= f_addr;
        e_addr_s  <= e_addr;
        e_wdata_s <= e_wdata;
    end

    // Memory responder: ack after a delay, optionally lingering one extra cycle.
    initial begin
        int d;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                d = (ack_delay < 0) ? $urandom_range(0, 3) : ack_delay;
                repeat (d) @(negedge clk);
                mem_ack   = 1'b1;
                mem_rdata = mem_array[mem_addr];
                if (mem_we === 1'b1) mem_array[mem_addr] = mem_wdata;
                @(negedge clk);
                if (ack_linger_en && $urandom_range(0, 1) == 1) @(negedge clk);
                mem_ack   = 1'b0;
                mem_rdata = 8'($urandom);
            end
        end
    end

    // Memory-side monitor: grant order from the round-robin rule and mem_* stability.
    initial begin
        logic          prev_req;
        int            win;
        logic          last_model;
        logic [AW-1:0] x_addr;
        logic          x_we;
        logic [DW-1:0] x_wdata;
        prev_req   = 1'b0;
        last_model = 1'b1;
        x_addr = '0; x_we = 1'b0; x_wdata = '0;
        forever begin
            @(negedge clk);
            if (rst_s === 1'b1) begin
                last_model = 1'b1;
            end else if (mem_req === 1'b1 && prev_req !== 1'b1) begin
                if (f_req_s && e_req_s) win = last_model ? 0 : 1;
                else if (f_req_s)       win = 0;
                else if (e_req_s)       win = 1;
                else                    win = -1;
                if (win < 0) begin
                    fail_now("grant_without_req: mem_req rose with no request pending");
                end else begin
                    x_addr  = (win == 1) ? e_addr_s : f_addr_s;
                    x_we    = (win == 1) ? e_we_s : 1'b0;
                    x_wdata = e_wdata_s;
                    grant_log.push_back(win);
                    last_model = (win == 1);
                    check("grant_mem_addr", 32'(mem_addr), 32'(x_addr));
                    check("grant_mem_we", 32'(mem_we), 32'(x_we));
                    if (x_we) check("grant_mem_wdata", 32'(mem_wdata), 32'(x_wdata));
                end
            end else if (mem_req === 1'b1) begin
                check("busy_mem_addr_stable", 32'(mem_addr), 32'(x_addr));
                check("busy_mem_we_stable", 32'(mem_we), 32'(x_we));
                if (x_we) check("busy_mem_wdata_stable", 32'(mem_wdata), 32'(x_wdata));
            end
            prev_req = mem_req;
        end
    end

    // Requester-side monitor: pops expected read data on each ready rise.
    initial begin
        logic pf, pe;
        pf = 1'b0;
        pe = 1'b0;
        forever begin
            @(negedge clk);
            if (f_ready === 1'b1 && pf !== 1'b1) begin
                check("ready_one_hot_f", 32'(e_ready), 32'd0);
                if (f_exp_q.size() == 0) fail_now("unexpected_f_ready: no fetch outstanding");
                else check("f_rdata", 32'(f_rdata), 32'(f_exp_q.pop_front()));
            end
            if (e_ready === 1'b1 && pe !== 1'b1) begin
                check("ready_one_hot_e", 32'(f_ready), 32'd0);
                if (e_exp_q.size() == 0) fail_now("unexpected_e_ready: no execute outstanding");
                else check("e_rdata", 32'(e_rdata), 32'(e_exp_q.pop_front()));
            end
            pf = f_ready;
            pe = e_ready;
        end
    end

    task automatic fetch_txn(input logic [AW-1:0] addr, output int cycles);
        @(negedge clk);
        f_addr = addr;
        f_req  = 1'b1;
        f_exp_q.push_back(ref_mem[addr]);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (f_ready !== 1'b1 && cycles < 300);
        if (f_ready !== 1'b1) fail_now($sformatf("fetch_timeout: addr %0h got no f_ready", addr));
        f_req = 1'b0;
    endtask

    task automatic exec_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        int cycles;
        @(negedge clk);
        e_we    = we;
        e_addr  = addr;
        e_wdata = wdata;
        e_req   = 1'b1;
        if (we) ref_mem[addr] = wdata;
        else    e_last_read = ref_mem[addr];
        e_exp_q.push_back(e_last_read);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (e_ready !== 1'b1 && cycles < 300);
        if (e_ready !== 1'b1) fail_now($sformatf("exec_timeout: addr %0h got no e_ready", addr));
        e_req = 1'b0;
    endtask

    task automatic wait_mem_req(input string name);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (mem_req !== 1'b1) fail_now({name, ": mem_req never rose"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int width;
        int n;
        rst = 1'b1;
        f_req = 1'b0; f_addr = '0;
        e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem_array[i] = 8'($urandom);
            ref_mem[i]   = mem_array[i];
        end
        mem_array[8'h10] = 8'h2B;
        ref_mem[8'h10]   = 8'h2B;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_f_ready", 32'(f_ready), 32'd0);
        check("rst_e_ready", 32'(e_ready), 32'd0);
        check("rst_f_rdata", 32'(f_rdata), 32'd0);
        check("rst_e_rdata", 32'(e_rdata), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;

        // Single fetch, ack in the first busy cycle.
        ack_delay = 0;
        fetch_txn(8'h10, cyc);
        check("fetch_latency", 32'(cyc), 32'd2);
        @(negedge clk);
        check("fetch_release_ready", 32'(f_ready), 32'd0);
        check("fetch_release_state", 32'(dbg_state), 32'd0);
        check("fetch_rdata_held", 32'(f_rdata), 32'h2B);

        // Execute write leaves e_rdata at its reset value.
        exec_txn(1'b1, 8'hF0, 8'h7E);
        @(negedge clk);
        check("write_e_rdata_held", 32'(e_rdata), 32'd0);

        // Both requesters contend for three rounds.
        grant_log.delete();
        fork
            begin
                fetch_txn(8'h21, cyc);
                fetch_txn(8'h22, cyc);
            end
            exec_txn(1'b0, 8'h85, '0);
        join
        check("rr_grant_count", 32'(grant_log.size()), 32'd3);
        if (grant_log.size() == 3) begin
            check("rr_grant0", 32'(grant_log[0]), 32'd0);
            check("rr_grant1", 32'(grant_log[1]), 32'd1);
            check("rr_grant2", 32'(grant_log[2]), 32'd0);
        end

        // Slow memory with an execute request arriving mid-wait.
        ack_delay = 5;
        grant_log.delete();
        fork
            begin
                fetch_txn(8'h30, cyc);
                check("slow_fetch_latency", 32'(cyc), 32'd7);
            end
            begin
                repeat (3) @(negedge clk);
                exec_txn(1'b0, 8'h90, '0);
            end
        join
        check("slow_grant_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check("slow_grant0", 32'(grant_log[0]), 32'd0);
            check("slow_grant1", 32'(grant_log[1]), 32'd1);
        end

        // Reset while a fetch is in flight; the late ack must not produce a ready.
        ack_delay = 4;
        @(negedge clk);
        f_addr = 8'h33;
        f_req  = 1'b1;
        wait_mem_req("abort_fetch");
        rst   = 1'b1;
        f_req = 1'b0;
        @(negedge clk);
        check("abort_mem_req", 32'(mem_req), 32'd0);
        check("abort_f_ready", 32'(f_ready), 32'd0);
        check("abort_e_ready", 32'(e_ready), 32'd0);
        check("abort_f_rdata", 32'(f_rdata), 32'd0);
        rst = 1'b0;
        e_last_read = '0;
        repeat (10) begin
            @(negedge clk);
            check("abort_no_ready", 32'({f_ready, e_ready}), 32'd0);
        end
        ack_delay = 1;
        grant_log.delete();
        fork
            fetch_txn(8'h44, cyc);
            exec_txn(1'b0, 8'hA0, '0);
        join
        check("post_rst_grant_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) check("post_rst_tie_to_f", 32'(grant_log[0]), 32'd0);

        // Execute request withdrawn while busy.
        ack_delay = 3;
        @(negedge clk);
        e_we = 1'b0; e_addr = 8'hB5; e_req = 1'b1;
        e_last_read = ref_mem[8'hB5];
        e_exp_q.push_back(e_last_read);
        @(negedge clk);
        wait_mem_req("withdraw");
        e_req = 1'b0;
        n = 0;
        while (e_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (e_ready !== 1'b1) fail_now("withdraw_timeout: e_ready never rose");
        width = 0;
        while (e_ready === 1'b1 && width < 10) begin
            @(negedge clk);
            width++;
        end
        check("withdraw_ready_width", 32'(width), 32'd1);
        check("withdraw_state_idle", 32'(dbg_state), 32'd0);

        // Randomized concurrent traffic; fetch and execute use disjoint address halves.
        ack_delay = -1;
        ack_linger_en = 1'b1;
        fork
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                fetch_txn(AW'($urandom_range(0, 127)), cyc);
            end
            for (int j = 0; j < 30; j++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                exec_txn(1'($urandom_range(0, 1)), AW'($urandom_range(128, 255)), 8'($urandom));
            end
        join
        repeat (5) @(negedge clk);
        check("f_queue_drained", 32'(f_exp_q.size()), 32'd0);
        check("e_queue_drained", 32'(e_exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 8-bit memory port between the instruction fetch unit (read-only) and the execute unit (read/write data-cell access).
- Sits between the two requesters and the memory.
- Round-robin arbitration, one transaction in flight at a time.
- Level req/ready handshake on both requester sides, matching the existing fetch handshake.

Parameters:
- ADDR_W, 8, address width of requesters and memory port
- DATA_W, 8, data width of requesters and memory port

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- f_req  input  1  fetch request, held high until f_ready seen
- f_addr  input  ADDR_W  fetch address, stable while f_req high
- f_rdata  output  DATA_W  fetched instruction byte
- f_ready  output  1  fetch transaction complete, f_rdata valid
- e_req  input  1  execute request, held high until e_ready seen
- e_we  input  1  execute write enable (1 = write, 0 = read)
- e_addr  input  ADDR_W  execute address
- e_wdata  input  DATA_W  execute write data
- e_rdata  output  DATA_W  execute read data
- e_ready  output  1  execute transaction complete
- mem_req  output  1  memory request
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid when mem_ack high
- mem_ack  input  1  memory completion, one or more cycles after mem_req

Behaviour:
- Reset (rst high at rising edge):
  - state=IDLE, last=E (so fetch wins the first tie).
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, f_ready, e_ready, f_rdata, e_rdata.
  - Reset mid-transaction aborts it: mem_req low after that edge; no ready is issued; the requester re-requests.
- State machine, states IDLE, BUSY, DONE; grant register g (F or E):
  - IDLE:
    - Neither req high: stay IDLE.
    - Only one req high: grant it.
    - Both high: grant the one not equal to last.
    - On grant: latch the winner's addr, and for E also we and wdata (fetch forces we=0) into mem_addr/mem_we/mem_wdata; set mem_req=1; set g; go BUSY.
  - BUSY:
    - mem_req held 1 and mem_* held stable.
    - Requester inputs are ignored, including a dropped req.
    - On mem_ack=1:
      - mem_req<=0, mem_we<=0.
      - If the grant is a read, capture mem_rdata into f_rdata or e_rdata per g; on an E write, e_rdata is unchanged.
      - Assert the granted ready (f_ready or e_ready) <=1; last<=g; go DONE.
  - DONE:
    - Granted ready held high while the granted req is high.
    - When the granted req is sampled low: ready<=0, go IDLE.
    - The other requester's req is sampled only in IDLE, so no new grant in DONE.
- Latency:
  - Req sampled at edge 0 gives mem_req high after edge 0.
  - With mem_ack high in the first BUSY cycle, ready is high after edge 1.
  - Release costs one edge; back-to-back grants are at least 3 edges apart.
- Only one of f_ready and e_ready is high at a time; mem_req is never high in IDLE or DONE.
- f_rdata and e_rdata hold their last captured value until the next read for that requester.
- mem_ack seen in IDLE or DONE is ignored.
- Req dropped during BUSY: transaction still completes; in DONE the req is seen low, so ready is high for exactly one cycle.
- Arbitration is evaluated only in IDLE; a req rising in BUSY or DONE waits.
- Width rule: addr and data are passed through unmodified, with no arithmetic.

Test Plan:
- Reset then single fetch: f_req=1, f_addr=8'h10, memory returns 8'h2B with ack one cycle after mem_req. Required: mem_addr=8'h10, mem_we=0, then f_ready=1, f_rdata=8'h2B. Drop f_req: f_ready=0 the next edge, state IDLE.
- Execute write: e_req=1, e_we=1, e_addr=8'hF0, e_wdata=8'h7E. Required: mem_we=1, mem_wdata=8'h7E, e_ready after ack, e_rdata unchanged (8'h00 from reset), f_ready stays 0.
- Simultaneous requests, three rounds: both reqs held, each side releasing on ready and re-raising. Required: grant order F, E, F; mem_addr alternates accordingly; never both readies high.
- Slow memory: mem_ack delayed 5 cycles. Required: mem_req and mem_addr stable for all 5 cycles; ready rises on the edge after ack; an e_req raised mid-wait is served only after f_req releases.
- Reset mid-BUSY: assert rst while mem_req=1. Required: after that edge mem_req=0, both readies 0; a later ack produces no ready; the next grant goes to F on a tie.
- Req withdrawn in BUSY: drop e_req before ack. Required: transaction completes, e_ready high for exactly one cycle, then IDLE.
